// File: rtl/display_scan_out.sv
// rtl/display_scan_out.sv - raster timing generator and pixel output stage for the panel
module display_scan_out #(
   parameter int          HSYNC_W  = 2,
   parameter int          VSYNC_W  = 1,
   parameter logic [31:0] FILL_PIX = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        CSDisplay,
   input  logic [9:0]  HBOut_PD,
   input  logic [9:0]  VBOut_PD,
   input  logic [9:0]  AIPOut_PD,
   input  logic [9:0]  AILOut_PD,
   input  logic [31:0] PixData,
   input  logic        PixValid,
   output logic        PixReady,
   output logic [31:0] PixelOut,
   output logic        DE,
   output logic        HSync,
   output logic        VSync,
   output logic        FrameDone,
   output logic [7:0]  FrameCnt,
   output logic        Underflow,
   output logic        ConfigErr
);

   // Sync widths widened by one bit so a 10-bit counter never wraps the compare.
   localparam logic [10:0] HSW = 11'(HSYNC_W);
   localparam logic [10:0] VSW = 11'(VSYNC_W);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

   state_t      state_q, state_d;
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic [9:0]  vline_q, vline_d;
   // Blank lines are walked as an active-length phase followed by a blank-length
   // phase so the horizontal counter stays within 10 bits.
   logic        vphase_q, vphase_d;
   logic [9:0]  aip_q, aip_d, hb_q, hb_d, ail_q, ail_d, vb_q, vb_d;
   logic [31:0] pix_q, pix_d;
   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic        fd_q, fd_d, uf_q, uf_d, ce_q, ce_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic        line_end, vline_end, frame_end, start;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      vline_d   = vline_q;
      vphase_d  = vphase_q;
      aip_d     = aip_q;
      hb_d      = hb_q;
      ail_d     = ail_q;
      vb_d      = vb_q;
      pix_d     = pix_q;
      de_d      = 1'b0;
      hs_d      = 1'b0;
      vs_d      = 1'b0;
      fd_d      = 1'b0;
      fcnt_d    = fcnt_q;
      uf_d      = uf_q;
      ce_d      = ce_q;
      line_end  = 1'b0;
      vline_end = 1'b0;
      frame_end = 1'b0;
      start     = 1'b0;

      case (state_q)
         IDLE: start = CSDisplay;
         ACTIVE: begin
            de_d  = 1'b1;
            pix_d = PixValid ? PixData : FILL_PIX;
            if (!PixValid) uf_d = 1'b1;
            if (hcnt_q == aip_q - 10'd1) begin
               if (hb_q != 10'd0) begin
                  state_d = HBLANK;
                  hcnt_d  = 10'd0;
               end else begin
                  line_end = 1'b1;
               end
            end else begin
               hcnt_d = hcnt_q + 10'd1;
            end
         end
         HBLANK: begin
            hs_d = ({1'b0, hcnt_q} < HSW);
            if (hcnt_q == hb_q - 10'd1) line_end = 1'b1;
            else                        hcnt_d   = hcnt_q + 10'd1;
         end
         VBLANK: begin
            vs_d = ({1'b0, vline_q} < VSW);
            if (!vphase_q) begin
               if (hcnt_q == aip_q - 10'd1) begin
                  if (hb_q != 10'd0) begin
                     vphase_d = 1'b1;
                     hcnt_d   = 10'd0;
                  end else begin
                     vline_end = 1'b1;
                  end
               end else begin
                  hcnt_d = hcnt_q + 10'd1;
               end
            end else begin
               if (hcnt_q == hb_q - 10'd1) vline_end = 1'b1;
               else                        hcnt_d    = hcnt_q + 10'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (line_end) begin
         hcnt_d = 10'd0;
         if (vcnt_q != ail_q - 10'd1) begin
            vcnt_d  = vcnt_q + 10'd1;
            state_d = ACTIVE;
         end else if (vb_q != 10'd0) begin
            state_d  = VBLANK;
            vline_d  = 10'd0;
            vphase_d = 1'b0;
         end else begin
            frame_end = 1'b1;
         end
      end

      if (vline_end) begin
         hcnt_d   = 10'd0;
         vphase_d = 1'b0;
         if (vline_q == vb_q - 10'd1) frame_end = 1'b1;
         else                         vline_d   = vline_q + 10'd1;
      end

      if (frame_end) begin
         fd_d    = 1'b1;
         fcnt_d  = fcnt_q + 8'd1;
         state_d = IDLE;
         start   = CSDisplay;
      end

      // Sizes are captured only here, so mid-frame edits wait for the next frame.
      if (start) begin
         if (AIPOut_PD != 10'd0 && AILOut_PD != 10'd0) begin
            aip_d   = AIPOut_PD;
            hb_d    = HBOut_PD;
            ail_d   = AILOut_PD;
            vb_d    = VBOut_PD;
            state_d = ACTIVE;
            hcnt_d  = 10'd0;
            vcnt_d  = 10'd0;
         end else begin
            ce_d    = 1'b1;
            state_d = IDLE;
         end
      end
   end

   // State, counters, latched sizes and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         vline_q  <= '0;
         vphase_q <= 1'b0;
         aip_q    <= '0;
         hb_q     <= '0;
         ail_q    <= '0;
         vb_q     <= '0;
         pix_q    <= '0;
         de_q     <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         fd_q     <= 1'b0;
         fcnt_q   <= '0;
         uf_q     <= 1'b0;
         ce_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         vline_q  <= vline_d;
         vphase_q <= vphase_d;
         aip_q    <= aip_d;
         hb_q     <= hb_d;
         ail_q    <= ail_d;
         vb_q     <= vb_d;
         pix_q    <= pix_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         fd_q     <= fd_d;
         fcnt_q   <= fcnt_d;
         uf_q     <= uf_d;
         ce_q     <= ce_d;
      end
   end

   assign PixReady  = (state_q == ACTIVE);
   assign PixelOut  = pix_q;
   assign DE        = de_q;
   assign HSync     = hs_q;
   assign VSync     = vs_q;
   assign FrameDone = fd_q;
   assign FrameCnt  = fcnt_q;
   assign Underflow = uf_q;
   assign ConfigErr = ce_q;

endmodule

// File: tb/tb_display_scan_out.sv
// tb/tb_display_scan_out.sv - randomized self-checking bench for display_scan_out
module tb_display_scan_out;

   localparam int          HSW  = 2;
   localparam int          VSW  = 1;
   localparam logic [31:0] FILL = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        CSDisplay;
   logic [9:0]  HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
   logic [31:0] PixData;
   logic        PixValid;
   logic        PixReady;
   logic [31:0] PixelOut;
   logic        DE, HSync, VSync, FrameDone, Underflow, ConfigErr;
   logic [7:0]  FrameCnt;

   int checks = 0;
   int errors = 0;

   display_scan_out #(.HSYNC_W(HSW), .VSYNC_W(VSW), .FILL_PIX(FILL)) dut (
      .clk(clk), .reset(reset), .CSDisplay(CSDisplay),
      .HBOut_PD(HBOut_PD), .VBOut_PD(VBOut_PD), .AIPOut_PD(AIPOut_PD), .AILOut_PD(AILOut_PD),
      .PixData(PixData), .PixValid(PixValid), .PixReady(PixReady), .PixelOut(PixelOut),
      .DE(DE), .HSync(HSync), .VSync(VSync), .FrameDone(FrameDone), .FrameCnt(FrameCnt),
      .Underflow(Underflow), .ConfigErr(ConfigErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // ---------------- behavioural reference: raster position from frame offset ----------------
   int          m_aip, m_hb, m_ail, m_vb, m_t;
   bit          m_run;
   logic [31:0] e_pix;
   logic        e_de, e_hs, e_vs, e_fd, e_uf, e_ce;
   logic [7:0]  e_fc;

   function automatic bit pos_active(input int t);
      int w = m_aip + m_hb;
      return (t / w) < m_ail && (t % w) < m_aip;
   endfunction

   function automatic bit pos_hsync(input int t);
      int w = m_aip + m_hb;
      int col = t % w;
      return (t / w) < m_ail && col >= m_aip && (col - m_aip) < imin(HSW, m_hb);
   endfunction

   function automatic bit pos_vsync(input int t);
      int row = t / (m_aip + m_hb);
      return row >= m_ail && (row - m_ail) < imin(VSW, m_vb);
   endfunction

   task automatic try_start();
      if (AIPOut_PD != 0 && AILOut_PD != 0) begin
         m_aip = int'(AIPOut_PD); m_hb = int'(HBOut_PD);
         m_ail = int'(AILOut_PD); m_vb = int'(VBOut_PD);
         m_run = 1'b1;
         m_t   = 0;
      end else begin
         e_ce = 1'b1;
      end
   endtask

   // Compare every cycle, then advance the reference by one cycle.
   always @(negedge clk) begin
      bit act;
      if (!reset) begin
         chk("rst_PixReady", 32'(PixReady), 0);
         chk("rst_PixelOut", PixelOut, 0);
         chk("rst_DE", 32'(DE), 0);
         chk("rst_FrameCnt", 32'(FrameCnt), 0);
         chk("rst_flags", {26'd0, HSync, VSync, FrameDone, Underflow, ConfigErr, 1'b0}, 0);
         m_run = 1'b0; m_t = 0;
         e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_uf = 0; e_ce = 0; e_fc = '0;
      end else begin
         act = m_run && pos_active(m_t);
         chk("PixReady", 32'(PixReady), 32'(act));
         chk("PixelOut", PixelOut, e_pix);
         chk("DE", 32'(DE), 32'(e_de));
         chk("HSync", 32'(HSync), 32'(e_hs));
         chk("VSync", 32'(VSync), 32'(e_vs));
         chk("FrameDone", 32'(FrameDone), 32'(e_fd));
         chk("FrameCnt", 32'(FrameCnt), 32'(e_fc));
         chk("Underflow", 32'(Underflow), 32'(e_uf));
         chk("ConfigErr", 32'(ConfigErr), 32'(e_ce));
         e_fd = 1'b0;
         e_de = act;
         e_hs = m_run && pos_hsync(m_t);
         e_vs = m_run && pos_vsync(m_t);
         if (act) begin
            e_pix = PixValid ? PixData : FILL;
            if (!PixValid) e_uf = 1'b1;
         end
         if (!m_run) begin
            if (CSDisplay) try_start();
         end else if (m_t == (m_aip + m_hb) * (m_ail + m_vb) - 1) begin
            e_fd  = 1'b1;
            e_fc  = e_fc + 8'd1;
            m_run = 1'b0;
            if (CSDisplay) try_start();
         end else begin
            m_t++;
         end
      end
   end

   // ---------------- per-frame activity counters for literal checks ----------------
   int cyc = 0, last_fd = 0, f_period = 0, fd_cnt = 0;
   int acc_run = 0, de_run = 0, hs_run = 0, vs_run = 0;
   int f_acc = 0, f_de = 0, f_hs = 0, f_vs = 0;

   always @(negedge clk) begin
      cyc++;
      if (FrameDone) begin
         f_acc = acc_run; acc_run = 0;
      end
      if (PixReady && PixValid) acc_run++;
      de_run += int'(DE); hs_run += int'(HSync); vs_run += int'(VSync);
      if (FrameDone) begin
         f_de = de_run; f_hs = hs_run; f_vs = vs_run;
         de_run = 0; hs_run = 0; vs_run = 0;
         f_period = cyc - last_fd; last_fd = cyc;
         fd_cnt++;
      end
   end

   task automatic clr_runs();
      acc_run = 0; de_run = 0; hs_run = 0; vs_run = 0;
   endtask

   // ---------------- pixel source ----------------
   int  drop_pct = 0;
   bit  inc_mode = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         PixData  = inc_mode ? PixData + 32'd1 : $urandom;
         PixValid = ($urandom_range(99) >= drop_pct);
      end
   end

   task automatic set_cfg(input int aip, input int hb, input int ail, input int vb);
      AIPOut_PD = 10'(aip); HBOut_PD = 10'(hb); AILOut_PD = 10'(ail); VBOut_PD = 10'(vb);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("reset_now_DE", 32'(DE), 0);
      chk("reset_now_PixelOut", PixelOut, 0);
      chk("reset_now_sync", {30'd0, HSync, VSync}, 0);
      @(posedge clk); #2;
      reset = 1'b1;
      clr_runs();
   endtask

   task automatic wait_fd(input int budget);
      int start = fd_cnt;
      int n = 0;
      while (fd_cnt == start && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      checks++;
      if (fd_cnt == start) begin
         errors++;
         $display("FAIL wait_fd: no FrameDone within %0d cycles", budget);
      end
   endtask

   initial begin
      int fd0;
      reset = 1'b0; CSDisplay = 1'b0; PixData = '0; PixValid = 1'b0;
      set_cfg(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;

      // Nominal 4x3 frame, 2-cycle hblank, 1 blank line, incrementing data.
      inc_mode = 1'b1;
      set_cfg(4, 2, 3, 1);
      @(posedge clk); #2;
      CSDisplay = 1'b1;
      clr_runs();
      wait_fd(100);
      chk("p1_FrameCnt", 32'(FrameCnt), 1);
      chk("p1_accepted", f_acc, 12);
      chk("p1_de_cycles", f_de, 12);
      chk("p1_hsync_cycles", f_hs, 6);
      chk("p1_vsync_cycles", f_vs, 6);
      wait_fd(100);
      chk("p1_period", f_period, 24);
      chk("p1_FrameCnt2", 32'(FrameCnt), 2);
      inc_mode = 1'b0;

      // One missing pixel on line 1.
      CSDisplay = 1'b0;
      do_reset();
      @(posedge clk); #2;
      CSDisplay = 1'b1;
      clr_runs();
      repeat (8) @(posedge clk);
      #2 PixValid = 1'b0;
      wait_fd(100);
      chk("p3_accepted", f_acc, 11);
      chk("p3_de_cycles", f_de, 12);
      chk("p3_Underflow", 32'(Underflow), 1);
      wait_fd(100);
      chk("p3_period", f_period, 24);
      chk("p3_Underflow_sticky", 32'(Underflow), 1);

      // Zero active width is rejected.
      CSDisplay = 1'b0;
      do_reset();
      set_cfg(0, 2, 3, 1);
      fd0 = fd_cnt;
      CSDisplay = 1'b1;
      repeat (30) @(posedge clk);
      #2;
      chk("p4_ConfigErr", 32'(ConfigErr), 1);
      chk("p4_PixReady", 32'(PixReady), 0);
      chk("p4_no_frames", fd_cnt - fd0, 0);
      chk("p4_FrameCnt", 32'(FrameCnt), 0);
      set_cfg(4, 2, 3, 1);
      do_reset();
      wait_fd(100);
      chk("p4_recover_FrameCnt", 32'(FrameCnt), 1);
      chk("p4_recover_ConfigErr", 32'(ConfigErr), 0);

      // No blanking at all.
      set_cfg(4, 0, 2, 0);
      do_reset();
      wait_fd(100);
      wait_fd(100);
      chk("p5_period", f_period, 8);
      chk("p5_de_cycles", f_de, 8);
      chk("p5_hsync_cycles", f_hs, 0);
      chk("p5_vsync_cycles", f_vs, 0);

      // Disable mid-frame: frame completes then the stage idles.
      set_cfg(4, 2, 3, 1);
      do_reset();
      repeat (10) @(posedge clk);
      #2 CSDisplay = 1'b0;
      wait_fd(100);
      chk("p6_FrameCnt", 32'(FrameCnt), 1);
      fd0 = fd_cnt;
      repeat (40) @(posedge clk);
      #2;
      chk("p6_idle_PixReady", 32'(PixReady), 0);
      chk("p6_no_more_frames", fd_cnt - fd0, 0);
      CSDisplay = 1'b1;
      repeat (9) @(posedge clk);
      do_reset();

      // Randomized configurations with pixel drops and mid-frame size edits.
      drop_pct = 15;
      for (int it = 0; it < 12; it++) begin
         set_cfg($urandom_range(10) == 0 ? 0 : $urandom_range(6, 1), $urandom_range(3),
                 $urandom_range(10) == 0 ? 0 : $urandom_range(3, 1), $urandom_range(2));
         CSDisplay = 1'b1;
         for (int c = 0; c < int'($urandom_range(200, 40)); c++) begin
            @(posedge clk); #2;
            if ($urandom_range(30) == 0)
               set_cfg($urandom_range(6, 1), $urandom_range(3), $urandom_range(3, 1), $urandom_range(2));
         end
         if ($urandom_range(1) == 0) begin
            CSDisplay = 1'b0;
            repeat (60) @(posedge clk);
            #2;
         end
         if ($urandom_range(3) == 0) do_reset();
      end
      CSDisplay = 1'b0;
      repeat (60) @(posedge clk);
      #2;
      chk("final_idle_PixReady", 32'(PixReady), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan_out.md
Name: display_scan_out

Overview:
- Display output stage, directly downstream of DataPath. Pops 32-bit pixel words from the DataPath output buffer over a valid/ready handshake.
- Generates raster timing for the panel from the programmed blanking and active sizes: DE, HSync, VSync, frame pulse.
- Timing never stalls. Missing pixels are replaced and flagged.

Parameters:
- HSYNC_W, 2, HSync width in cycles, placed at start of horizontal blank.
- VSYNC_W, 1, VSync width in lines, placed at start of vertical blank.
- FILL_PIX, 32'h0, word driven on PixelOut during underflow.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- CSDisplay  in  1  display enable
- HBOut_PD  in  10  horizontal blank cycles per line
- VBOut_PD  in  10  vertical blank lines per frame
- AIPOut_PD  in  10  active pixels per line
- AILOut_PD  in  10  active lines per frame
- PixData  in  32  pixel word from DataPath
- PixValid  in  1  PixData valid
- PixReady  out  1  stage accepts PixData this cycle
- PixelOut  out  32  registered pixel to panel
- DE  out  1  data enable
- HSync  out  1  horizontal sync, active high
- VSync  out  1  vertical sync, active high
- FrameDone  out  1  one-cycle pulse at end of each frame
- FrameCnt  out  8  completed-frame counter, wraps 255->0
- Underflow  out  1  sticky: active pixel slot found PixValid low
- ConfigErr  out  1  sticky: AIP or AIL was zero at frame start

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters 0; PixReady, PixelOut, DE, HSync, VSync, FrameDone, FrameCnt, Underflow and ConfigErr all 0. Reset mid-frame aborts the frame with no FrameDone.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - CSDisplay=1, AIP!=0 and AIL!=0: latch all four sizes; next cycle enters ACTIVE with hcnt=0, vcnt=0.
  - CSDisplay=1 with AIP=0 or AIL=0: set ConfigErr and stay IDLE.
- Size changes take effect only at frame start (latched copies).
- ACTIVE:
  - PixReady=1 combinationally; a word transfers when PixValid&PixReady.
  - PixValid=0: FILL_PIX is substituted, Underflow is set, and timing still advances.
  - At hcnt=AIP-1: go to HBLANK if HB>0, else end the line.
- HBLANK: PixReady=0. At hcnt=HB-1, end the line.
- Line end:
  - vcnt<AIL-1: vcnt++, go to ACTIVE.
  - Last active line with VB>0: go to VBLANK, vline=0.
  - Last active line with VB=0: end the frame.
- VBLANK:
  - PixReady=0. Each blank line is AIP+HB cycles.
  - At the last cycle of line VB-1, end the frame.
- Frame end:
  - FrameDone=1 for one cycle, FrameCnt++.
  - If CSDisplay=1: re-latch sizes (re-check for zero) and enter ACTIVE next cycle with no gap.
  - Else go to IDLE.
- Deasserting CSDisplay mid-frame completes the current frame.
- Output alignment:
  - PixelOut, DE, HSync and VSync are registered and lag the internal state by exactly 1 cycle.
  - A word accepted at cycle N appears on PixelOut with DE=1 at N+1.
  - PixelOut holds its last value when DE=0.
  - DE=1 only for ACTIVE cycles.
- Sync generation:
  - HSync=1 for HBLANK cycles with hcnt<min(HSYNC_W,HB). No HSync if HB=0.
  - VSync=1 for all cycles of VBLANK lines with vline<min(VSYNC_W,VB).
- Frame length is (AIP+HB)*(AIL+VB) cycles. Exactly AIP*AIL handshake slots per frame.
- Counters are 10-bit, compare against latched sizes, and never exceed them. Sizes up to 1023 are supported.
- Sticky flags clear only on reset.

Test Plan:
- AIP=4, HB=2, AIL=3, VB=1, PixValid=1 always, CSDisplay=1 → 12 words accepted, DE high 4 of every 6 cycles for 3 lines; 6-cycle VBLANK line with VSync=1; FrameDone every 24 cycles; FrameCnt=1 after the first frame.
- Same config, incrementing PixData → PixelOut sequence equals input order, each word 1 cycle after acceptance; HSync=1 for exactly 2 cycles at the start of each HBLANK.
- PixValid dropped for 1 cycle on line 1 → that slot outputs FILL_PIX with DE=1, Underflow=1 sticky, frame length still 24 cycles.
- AIP=0, CSDisplay=1 → ConfigErr=1, stays IDLE, PixReady=0, no FrameDone; after reset and AIP=4 → normal frames.
- HB=0, VB=0, AIP=4, AIL=2 → DE continuously 1, HSync/VSync never asserted, FrameDone every 8 cycles.
- CSDisplay cleared mid-frame → frame completes, FrameDone pulses, returns to IDLE; reset asserted mid-line → all outputs 0 immediately.
